addertree_pipe_acc: RTL and testbench
=====================================

ADDERTREE_PIPE_ACC -- requirements
Module: addertree_pipe_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 23, the bit width of each operand (unsigned).
REQ-002 SHALL have parameter NUM, default 6, the operand count per beat, legal range 2..16.
REQ-003 SHALL have parameter ACC_BITS, default 4, the extra headroom bits for multi-beat accumulation.
REQ-004 SHALL derive localparam OUT_W = WIDTH + clog2(NUM) + ACC_BITS (defaults give 30).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port A, input, NUM*WIDTH bits: operands; operand k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid, input, 1 bit: a beat of A is offered.
REQ-009 SHALL have port in_last, input, 1 bit: the beat closes the current accumulation frame.
REQ-010 SHALL have port mode, input, 1 bit: 0 = per-beat sum, 1 = accumulate over a frame.
REQ-011 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-012 SHALL have port S, output, OUT_W bits: the frame sum.
REQ-013 SHALL have port out_valid, output, 1 bit: S, ovf and beats are valid.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-015 SHALL have port ovf, output, 1 bit: the frame sum exceeded 2^OUT_W-1 (S wrapped).
REQ-016 SHALL have port beats, output, 8 bits: the number of beats in the frame, saturating at 255.

Function
REQ-017 SHALL accept a beat when in_valid && in_ready.
REQ-018 SHALL drive in_ready = !(out_valid && !out_ready); stall is global, so all stages freeze while stalled.
REQ-019 SHALL register NUM operands reduced to carry-save pair (sum, carry) in pipeline stage 1.
REQ-020 SHALL perform the final carry-propagate add in stage 2, and accumulate and register the output in stage 3.
REQ-021 SHALL set latency from the accepting edge of the last beat of a frame to out_valid high at exactly 3 cycles, absent stalls.
REQ-022 SHALL compute each beat sum exactly as the sum of NUM operands, zero-extended, with no loss in WIDTH+clog2(NUM) bits.
REQ-023 SHALL in mode 0 treat every beat as a complete frame (in_last ignored, beats=1).
REQ-024 SHALL latch mode on the first beat of a frame; mode changes mid-frame are ignored until the frame closes.
REQ-025 SHALL run an accumulator FSM with states IDLE and ACCUM.
REQ-026 SHALL in IDLE on the first-beat sum with last=1 load the output register and stay in IDLE.
REQ-027 SHALL in IDLE on the first-beat sum with last=0 load acc=sum and beat count 1, then go to ACCUM.
REQ-028 SHALL in ACCUM on each beat sum set acc = (acc + sum) mod 2^OUT_W and increment the beat count (saturating).
REQ-029 SHALL in ACCUM on a beat with last=1 load the output register and return to IDLE.
REQ-030 SHALL set ovf when any accumulation carries out of bit OUT_W-1; ovf is sticky for the frame and cleared at the next frame start.
REQ-031 SHALL hold out_valid high with S, ovf and beats stable until out_ready; the result is consumed on out_valid && out_ready.
REQ-032 SHALL allow consumption and a new result in the same cycle, giving back-to-back results with no bubble.
REQ-033 SHALL carry no data through stage bubbles: stage valid bits gate accumulation and the FSM.
REQ-034 SHALL deliver frames in acceptance order with no loss or duplication under any out_ready pattern.

Reset
REQ-035 SHALL on rst asynchronously clear out_valid, S, ovf, beats, all stage valids, acc and the beat count, and set the FSM to IDLE.
REQ-036 SHALL drive in_ready to 1 while rst is asserted and after its release (nothing is held).
REQ-037 SHALL discard a partial frame on reset mid-frame; the first post-reset beat starts a new frame.

Verification
REQ-038 SHALL pass this scenario: mode 0, all six operands 0x7FFFFF, out_ready=1 → at 3 cycles S=50331642 (0x2FFFFFA), ovf=0, beats=1.
REQ-039 SHALL pass this scenario: mode 1, 3 beats of all-0x7FFFFF with last on beat 3 → a single result S=150994926, beats=3, ovf=0, no out_valid on beats 1-2.
REQ-040 SHALL pass this scenario: mode 1, 22 beats of all-0x7FFFFF → S=33554300, ovf=1, beats=22.
REQ-041 SHALL pass this scenario: 10 random mode-0 beats with out_ready low for 5 cycles mid-stream → in_ready falls, all 10 sums arrive in order and match the golden sum.
REQ-042 SHALL pass this scenario: mode 1, rst pulsed after 2 of 4 beats, then a 1-beat frame of operands 1..6 → S=21, beats=1, ovf=0, no stale data.
REQ-043 SHALL pass this scenario: 200 random frames of mixed mode, random lengths and random out_ready, compared against a scoreboard model of the sum mod 2^OUT_W → zero mismatches.

Source files
------------

// File: rtl/addertree_pipe_acc.sv
// addertree_pipe_acc: sums NUM unsigned operands per beat through a
// three-stage pipeline (carry-save reduce, carry-propagate add, accumulate)
// and either reports every beat sum or accumulates beats into a frame sum.
// A single global stall freezes every stage while a result waits downstream.
module addertree_pipe_acc #(
    parameter int WIDTH    = 23,
    parameter int NUM      = 6,
    parameter int ACC_BITS = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM*WIDTH-1:0]                     A,
    input  logic                                     in_valid,
    input  logic                                     in_last,
    input  logic                                     mode,
    output logic                                     in_ready,
    output logic [WIDTH+$clog2(NUM)+ACC_BITS-1:0]    S,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     ovf,
    output logic [7:0]                               beats
);

    localparam int SW    = WIDTH + $clog2(NUM);  // exact width of one beat sum
    localparam int OUT_W = SW + ACC_BITS;

    typedef enum logic {IDLE, ACCUM} state_t;

    // Input side / frame tracking
    logic              accept;
    logic              eff_mode;
    logic              eff_last;
    logic              frame_open_q;

    // Carry-save reduction
    logic [SW-1:0]     csa_s, csa_c, csa_op, csa_t;

    // Stage registers
    logic              v1_q, last1_q;
    logic [SW-1:0]     s1_q, c1_q;
    logic              v2_q, last2_q;
    logic [SW-1:0]     sum2_q;

    // Accumulator / output stage
    state_t            state_q;
    logic [OUT_W-1:0]  acc_q;
    logic [7:0]        cnt_q;
    logic              accovf_q;
    logic              out_valid_q;
    logic [OUT_W-1:0]  s_q;
    logic              ovf_q;
    logic [7:0]        beats_q;

    logic [OUT_W-1:0]  sum_ext;
    logic [OUT_W-1:0]  acc_sum;
    logic              acc_co;
    logic [7:0]        cnt_inc;

    // Everything advances unless a finished result is still waiting.
    assign in_ready = !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;

    // An open frame pins mode to accumulate; mode-0 beats always close themselves.
    assign eff_mode = frame_open_q | mode;
    assign eff_last = !eff_mode | in_last;

    // Track whether an accumulate frame is in progress at the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_open_q <= 1'b0;
        end else if (accept) begin
            frame_open_q <= !eff_last;
        end
    end

    // Reduce the NUM operands to a sum/carry pair with a chain of 3:2 compressors.
    // Bits shifted out of the carry are harmless: the true sum fits in SW bits.
    always_comb begin
        csa_s  = '0;
        csa_c  = '0;
        csa_op = '0;
        csa_t  = '0;
        for (int k = 0; k < NUM; k++) begin
            csa_op = SW'(A[k*WIDTH +: WIDTH]);
            csa_t  = csa_s ^ csa_c ^ csa_op;
            csa_c  = ((csa_s & csa_c) | (csa_s & csa_op) | (csa_c & csa_op)) << 1;
            csa_s  = csa_t;
        end
    end

    // Stage 1: register the carry-save pair and the beat's frame-close flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            s1_q    <= '0;
            c1_q    <= '0;
        end else if (in_ready) begin
            v1_q <= accept;
            if (accept) begin
                last1_q <= eff_last;
                s1_q    <= csa_s;
                c1_q    <= csa_c;
            end
        end
    end

    // Stage 2: final carry-propagate add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            sum2_q  <= '0;
        end else if (in_ready) begin
            v2_q <= v1_q;
            if (v1_q) begin
                last2_q <= last1_q;
                sum2_q  <= s1_q + c1_q;
            end
        end
    end

    // Next accumulator value with carry-out, and saturating beat count.
    always_comb begin
        sum_ext           = OUT_W'(sum2_q);
        {acc_co, acc_sum} = {1'b0, acc_q} + {1'b0, sum_ext};
        cnt_inc           = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end

    // Stage 3: accumulator FSM and output register; only valid beats touch state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            accovf_q    <= 1'b0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            ovf_q       <= 1'b0;
            beats_q     <= '0;
        end else if (in_ready) begin
            // Any held result is consumed this edge; replace it only if a frame closes.
            out_valid_q <= v2_q && last2_q;
            if (v2_q) begin
                case (state_q)
                    IDLE: begin
                        if (last2_q) begin
                            s_q     <= sum_ext;
                            ovf_q   <= 1'b0;
                            beats_q <= 8'd1;
                        end else begin
                            acc_q    <= sum_ext;
                            cnt_q    <= 8'd1;
                            accovf_q <= 1'b0;
                            state_q  <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (last2_q) begin
                            s_q     <= acc_sum;
                            ovf_q   <= accovf_q | acc_co;
                            beats_q <= cnt_inc;
                            state_q <= IDLE;
                        end else begin
                            acc_q    <= acc_sum;
                            accovf_q <= accovf_q | acc_co;
                            cnt_q    <= cnt_inc;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign S         = s_q;
    assign ovf       = ovf_q;
    assign beats     = beats_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_addertree_pipe_acc.sv
// Scoreboard bench for addertree_pipe_acc: a behavioural model computes the
// exact frame total when each beat is accepted and queues the expected result;
// a monitor pops and compares on every consumed output.
module tb_addertree_pipe_acc;

    localparam int WIDTH    = 23;
    localparam int NUM      = 6;
    localparam int ACC_BITS = 4;
    localparam int OUT_W    = WIDTH + $clog2(NUM) + ACC_BITS;
    localparam longint MODV = longint'(1) << OUT_W;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM*WIDTH-1:0]   A = '0;
    logic                   in_valid = 1'b0;
    logic                   in_last = 1'b0;
    logic                   mode = 1'b0;
    logic                   in_ready;
    logic [OUT_W-1:0]       S;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic                   ovf;
    logic [7:0]             beats;

    typedef struct {
        longint s;
        logic   ovf;
        int     beats;
    } res_t;

    res_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     n_results = 0;
    longint last_s;
    logic   last_ovf;
    int     last_beats;
    bit     rnd_rdy = 0;
    bit     saw_stall = 0;
    bit     m_open = 0;
    longint m_tot = 0;
    int     m_cnt = 0;

    addertree_pipe_acc #(.WIDTH(WIDTH), .NUM(NUM), .ACC_BITS(ACC_BITS)) dut (
        .clk(clk), .rst(rst), .A(A), .in_valid(in_valid), .in_last(in_last),
        .mode(mode), .in_ready(in_ready), .S(S), .out_valid(out_valid),
        .out_ready(out_ready), .ovf(ovf), .beats(beats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint beat_sum(input logic [NUM*WIDTH-1:0] a);
        longint s = 0;
        for (int k = 0; k < NUM; k++) s += longint'(a[k*WIDTH +: WIDTH]);
        return s;
    endfunction

    task automatic push_res(input longint tot, input int cnt);
        res_t r;
        r.s     = tot % MODV;
        r.ovf   = (tot >= MODV);
        r.beats = (cnt > 255) ? 255 : cnt;
        exp_q.push_back(r);
    endtask

    task automatic model_accept(input logic [NUM*WIDTH-1:0] a, input bit last, input bit m);
        longint bs = beat_sum(a);
        if (!(m_open || m)) begin
            push_res(bs, 1);
        end else begin
            if (!m_open) begin
                m_tot = 0;
                m_cnt = 0;
            end
            m_tot += bs;
            m_cnt++;
            if (last) begin
                push_res(m_tot, m_cnt);
                m_open = 0;
            end else begin
                m_open = 1;
            end
        end
    endtask

    // Offer one beat (starting just after a rising edge) until it is accepted.
    task automatic send_beat(input logic [NUM*WIDTH-1:0] a, input bit last, input bit m);
        bit got = 0;
        int n = 0;
        A = a; in_last = last; mode = m; in_valid = 1'b1;
        while (!got && n < 200) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (got) model_accept(a, last, m);
        else chk("accept_timeout", 64'(got), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic rand_a(output logic [NUM*WIDTH-1:0] a);
        for (int k = 0; k < NUM; k++) a[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_S", 64'(S), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_beats", 64'(beats), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_open = 0;
        exp_q.delete();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic wait_results(input int target);
        int n = 0;
        while (n_results < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("result_timeout", 64'(n_results >= target), 64'd1);
    endtask

    // Monitor: compare every consumed result against the head of the scoreboard.
    always @(negedge clk) begin : mon
        res_t e;
        if (!rst && !in_ready) saw_stall = 1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(S), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_S", 64'(S), 64'(e.s));
                chk("sb_ovf", 64'(ovf), 64'(e.ovf));
                chk("sb_beats", 64'(beats), 64'(e.beats));
            end
            last_s = longint'(S);
            last_ovf = ovf;
            last_beats = int'(beats);
            n_results++;
        end
    end

    // Random backpressure, enabled only for the random phase.
    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [NUM*WIDTH-1:0] a;
        int base;
        int len;
        int n;

        do_reset();

        // Mode 0, all operands max: latency and exact value.
        for (int k = 0; k < NUM; k++) a[k*WIDTH +: WIDTH] = 23'h7FFFFF;
        send_beat(a, 1'b0, 1'b0);
        @(negedge clk); chk("lat_edge1", 64'(out_valid), 64'd0);
        @(negedge clk); chk("lat_edge2", 64'(out_valid), 64'd0);
        @(negedge clk); chk("lat_edge3", 64'(out_valid), 64'd1);
        chk("m0_S", 64'(S), 64'd50331642);
        chk("m0_ovf", 64'(ovf), 64'd0);
        chk("m0_beats", 64'(beats), 64'd1);
        @(posedge clk); #1;

        // Mode 1, three-beat frame.
        base = n_results;
        for (int b = 0; b < 3; b++) send_beat(a, b == 2, 1'b1);
        chk("m1_no_early", 64'(n_results), 64'(base));
        wait_results(base + 1);
        chk("m1_S", 64'(last_s), 64'd150994926);
        chk("m1_beats", 64'(last_beats), 64'd3);
        chk("m1_ovf", 64'(last_ovf), 64'd0);

        // Mode 1, 22 beats: wraps once.
        base = n_results;
        for (int b = 0; b < 22; b++) send_beat(a, b == 21, 1'b1);
        wait_results(base + 1);
        chk("wrap_S", 64'(last_s), 64'd33554300);
        chk("wrap_ovf", 64'(last_ovf), 64'd1);
        chk("wrap_beats", 64'(last_beats), 64'd22);

        // Ten random mode-0 beats with a 5-cycle consumer stall mid-stream.
        base = n_results;
        saw_stall = 0;
        fork
            begin
                logic [NUM*WIDTH-1:0] r;
                for (int b = 0; b < 10; b++) begin
                    rand_a(r);
                    send_beat(r, 1'b1, 1'b0);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_results(base + 10);
        chk("stall_seen", 64'(saw_stall), 64'd1);

        // Reset in the middle of an accumulate frame, then a fresh one-beat frame.
        for (int b = 0; b < 2; b++) send_beat(a, 1'b0, 1'b1);
        do_reset();
        base = n_results;
        for (int k = 0; k < NUM; k++) a[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
        send_beat(a, 1'b1, 1'b1);
        wait_results(base + 1);
        chk("post_rst_S", 64'(last_s), 64'd21);
        chk("post_rst_beats", 64'(last_beats), 64'd1);
        chk("post_rst_ovf", 64'(last_ovf), 64'd0);
        chk("post_rst_count", 64'(n_results), 64'(base + 1));

        // Long frame: beat count saturates at 255.
        base = n_results;
        for (int b = 0; b < 300; b++) begin
            rand_a(a);
            send_beat(a, b == 299, 1'b1);
        end
        wait_results(base + 1);
        chk("sat_beats", 64'(last_beats), 64'd255);
        chk("sat_ovf", 64'(last_ovf), 64'd1);

        // 200 random frames, mixed mode (mid-frame mode flips), random backpressure.
        rnd_rdy = 1;
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 1) == 0) begin
                rand_a(a);
                send_beat(a, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                len = $urandom_range(1, 6);
                for (int b = 0; b < len; b++) begin
                    rand_a(a);
                    send_beat(a, b == len - 1, (b == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
                end
            end
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rnd_rdy = 0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
